// File: rtl/muldiv_unit_if.sv
// Request/result bundle of the iterative multiply/divide unit.
// The master issues start/op/operands; the slave returns status and results.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Works on operand magnitudes; signs are applied in a dedicated FIXSIGN cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CALC    = 2'd1,
        FIXSIGN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             is_div_q, is_div_d;
    logic             is_signed_q, is_signed_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             in_neg_a;
    logic             in_neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0] quo_neg;
    logic [WIDTH-1:0] rem_neg;

    // Datapath arithmetic: operand magnitudes, one iteration step, sign negations.
    always_comb begin
        in_neg_a  = ~bus.op[0] & bus.src_a[WIDTH-1];
        in_neg_b  = ~bus.op[0] & bus.src_b[WIDTH-1];
        mag_a     = in_neg_a ? (~bus.src_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_a;
        mag_b     = in_neg_b ? (~bus.src_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.src_b;
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        // The partial remainder is always below the divisor, so the difference fits WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - opnd_q;
        prod_neg  = ~{acc_hi_q, acc_lo_q} + {{(2*WIDTH-1){1'b0}}, 1'b1};
        quo_neg   = ~acc_lo_q + {{(WIDTH-1){1'b0}}, 1'b1};
        rem_neg   = ~acc_hi_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    // Next-state and next-register values for the control FSM and accumulators.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        opnd_d      = opnd_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        div_zero_d  = div_zero_q;
        hi_d        = hi_q;
        lo_d        = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_div_d    = bus.op[1];
                    is_signed_d = ~bus.op[0];
                    neg_a_d     = in_neg_a;
                    neg_b_d     = in_neg_b;
                    if (bus.op[1] && (bus.src_b == {WIDTH{1'b0}})) begin
                        state_d    = DONE;
                        div_zero_d = 1'b1;
                    end else begin
                        state_d  = CALC;
                        cnt_d    = CW'(WIDTH - 1);
                        acc_hi_d = {WIDTH{1'b0}};
                        if (bus.op[1]) begin
                            acc_lo_d = mag_a;
                            opnd_d   = mag_b;
                        end else begin
                            acc_lo_d = mag_b;
                            opnd_d   = mag_a;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_hi_d = div_ge ? div_sub : div_shift[WIDTH-1:0];
                    acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                end else begin
                    {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = FIXSIGN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIXSIGN: begin
                state_d    = DONE;
                div_zero_d = 1'b0;
                if (is_signed_q && is_div_q) begin
                    lo_d = (neg_a_q ^ neg_b_q) ? quo_neg : acc_lo_q;
                    hi_d = neg_a_q ? rem_neg : acc_hi_q;
                end else if (is_signed_q) begin
                    {hi_d, lo_d} = (neg_a_q ^ neg_b_q) ? prod_neg : {acc_hi_q, acc_lo_q};
                end else begin
                    hi_d = acc_hi_q;
                    lo_d = acc_lo_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= {CW{1'b0}};
            acc_hi_q    <= {WIDTH{1'b0}};
            acc_lo_q    <= {WIDTH{1'b0}};
            opnd_q      <= {WIDTH{1'b0}};
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            opnd_q      <= opnd_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values: even integers from 4 to 64.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-low.
REQ-004 start  input  1  request pulse; sampled only while in IDLE.
REQ-005 op  input  2  operation, sampled with start: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-006 src_a  input  WIDTH  multiplicand or dividend, sampled with start.
REQ-007 src_b  input  WIDTH  multiplier or divisor, sampled with start.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 div_zero  output  1  last completed operation was a DIV or DIVU with src_b == 0.
REQ-011 hi  output  WIDTH  MULT: upper product half; DIV: remainder.
REQ-012 lo  output  WIDTH  MULT: lower product half; DIV: quotient.

Function
REQ-013 The unit SHALL use four states: IDLE, CALC, FIXSIGN and DONE.
REQ-014 IDLE with start=1 SHALL capture op, src_a and src_b, then go to CALC. A division with src_b == 0 SHALL go straight to DONE instead.
REQ-015 CALC SHALL run exactly WIDTH cycles, using an internal count from WIDTH-1 down to 0.
REQ-016 Each CALC cycle SHALL process one bit: shift-add on operand magnitudes for multiply, restoring shift-subtract on magnitudes for divide.
REQ-017 CALC SHALL go to FIXSIGN when the count reaches 0.
REQ-018 FIXSIGN SHALL take one cycle and apply the signs for signed ops:
- product negated when the operand signs differ;
- quotient negated when the operand signs differ;
- remainder takes the dividend's sign.
FIXSIGN SHALL then go to DONE.
REQ-019 FIXSIGN SHALL pass unsigned ops through unchanged.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 hi, lo and div_zero SHALL update only on entry to DONE and hold their values at all other times.
REQ-022 Latency: with start accepted in cycle 0, done=1 SHALL occur in cycle WIDTH+2. For a divide-by-zero, done=1 SHALL occur in cycle 1.
REQ-023 Divide-by-zero SHALL set div_zero=1 and leave hi and lo unchanged. Every other completion SHALL clear div_zero to 0.
REQ-024 MULT/MULTU SHALL produce {hi,lo} = the exact 2*WIDTH-bit product.
REQ-025 DIV/DIVU SHALL truncate toward zero, with src_a = lo*src_b + hi.
REQ-026 Signed DIV of the most-negative value by -1 SHALL give lo = the most-negative value and hi = 0, with no error flag.
REQ-027 start while busy=1 SHALL be ignored; no queuing. Operands changing after the start cycle SHALL NOT affect the result.
REQ-028 start=1 in the DONE cycle SHALL be ignored. A new request is accepted no earlier than the following IDLE cycle.
REQ-029 Back-to-back operations SHALL work with one IDLE cycle between done and the next accepted start.

Reset
REQ-030 reset=0 at a rising edge SHALL force, on that edge:
- state IDLE and internal count 0;
- busy=0, done=0, div_zero=0, hi=0, lo=0.
REQ-031 Reset asserted mid-operation SHALL abandon the operation; no done pulse SHALL follow it.
REQ-032 Reset SHALL take priority over start on the same edge.

Verification (WIDTH=32)
REQ-033 MULT src_a=0xFFFFFFFD (-3), src_b=7 -> done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 MULTU src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, div_zero=0.
REQ-035 Signed division cases:
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
- DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 0xFFFFFFFF / 0x10 -> lo=0x0FFFFFFF, hi=0x0000000F.
REQ-037 After REQ-036, DIV 5/0 -> done in cycle 1, div_zero=1, hi/lo still 0x0000000F / 0x0FFFFFFF. A following MULTU 2*3 -> div_zero=0, lo=6.
REQ-038 Reset and busy checks:
- start MULT, assert reset=0 in cycle 10 -> busy=0 and hi=lo=0 next cycle, no done within 40 cycles;
- start pulses while busy -> result matches the first request only.
